mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between two requesters: the instruction-fetch path (port 0) and the load/store path (port 1).
- Each requester uses a valid/ready request handshake and gets a one-cycle response pulse.
- The block sequences the memory's write enable, funct3, address and data signals, and waits out the memory's registered read latency.
- It sits between the core's control FSM and the memory block, so fetch and load/store stages issue requests instead of driving memory pins directly.

---
 rtl/mem_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates fetch (port 0) and load/store (port 1) onto one
//               unified memory port with a registered read latency.
//               Optional counters are enabled by defining MEM_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic              d_write,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_write_mem,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_d_stall,
    output logic [31:0]       perf_forced
`endif
);

    localparam int          SC_W        = $clog2(STARVE_LIMIT + 1);
    localparam logic [2:0]  FUNCT3_WORD = 3'b010;
    localparam logic [1:0]  LAT_LOAD    = 2'(READ_LATENCY - 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              owner_data, owner_data_nx;
    logic              is_write, is_write_nx;
    logic [1:0]        lat_cnt, lat_cnt_nx;
    logic [SC_W-1:0]   starve_cnt, starve_cnt_nx;

    logic              if_rvalid_nx, d_rvalid_nx, mem_write_mem_nx;
    logic [DATA_W-1:0] if_rdata_nx, d_rdata_nx, mem_write_data_nx;
    logic [2:0]        mem_funct3_nx;
    logic [ADDR_W-1:0] mem_write_address_nx, mem_read_address_nx;

    logic              starved;
    logic              grant_if;
    logic              grant_d;

    // Data normally wins a tie; a starved fetch overrides it.
    assign starved  = (starve_cnt == STARVE_MAX);
    assign grant_if = (state == S_IDLE) && if_valid && (!d_valid || starved);
    assign grant_d  = (state == S_IDLE) && d_valid && !grant_if;
    assign if_ready = grant_if;
    assign d_ready  = grant_d;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            owner_data        <= 1'b0;
            is_write          <= 1'b0;
            lat_cnt           <= '0;
            starve_cnt        <= '0;
            if_rvalid         <= 1'b0;
            if_rdata          <= '0;
            d_rvalid          <= 1'b0;
            d_rdata           <= '0;
            mem_write_mem     <= 1'b0;
            mem_funct3        <= FUNCT3_WORD;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            mem_read_address  <= '0;
        end else begin
            state             <= state_nx;
            owner_data        <= owner_data_nx;
            is_write          <= is_write_nx;
            lat_cnt           <= lat_cnt_nx;
            starve_cnt        <= starve_cnt_nx;
            if_rvalid         <= if_rvalid_nx;
            if_rdata          <= if_rdata_nx;
            d_rvalid          <= d_rvalid_nx;
            d_rdata           <= d_rdata_nx;
            mem_write_mem     <= mem_write_mem_nx;
            mem_funct3        <= mem_funct3_nx;
            mem_write_address <= mem_write_address_nx;
            mem_write_data    <= mem_write_data_nx;
            mem_read_address  <= mem_read_address_nx;
        end
    end

    always_comb begin
        state_nx             = state;
        owner_data_nx        = owner_data;
        is_write_nx          = is_write;
        lat_cnt_nx           = lat_cnt;
        starve_cnt_nx        = starve_cnt;
        if_rvalid_nx         = 1'b0;
        if_rdata_nx          = if_rdata;
        d_rvalid_nx          = 1'b0;
        d_rdata_nx           = d_rdata;
        mem_write_mem_nx     = mem_write_mem;
        mem_funct3_nx        = mem_funct3;
        mem_write_address_nx = mem_write_address;
        mem_write_data_nx    = mem_write_data;
        mem_read_address_nx  = mem_read_address;

        if (grant_if) begin
            starve_cnt_nx = '0;
        end else if ((state == S_IDLE) && if_valid && !starved) begin
            starve_cnt_nx = starve_cnt + SC_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (grant_if) begin
                    owner_data_nx       = 1'b0;
                    is_write_nx         = 1'b0;
                    mem_funct3_nx       = FUNCT3_WORD;
                    mem_read_address_nx = if_addr;
                    state_nx            = S_ISSUE;
                end else if (grant_d) begin
                    owner_data_nx = 1'b1;
                    is_write_nx   = d_write;
                    mem_funct3_nx = d_funct3;
                    if (d_write) begin
                        mem_write_mem_nx     = 1'b1;
                        mem_write_address_nx = d_addr;
                        mem_write_data_nx    = d_wdata;
                    end else begin
                        mem_read_address_nx = d_addr;
                    end
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (is_write) begin
                    // The memory commits the write on this edge; ack at once.
                    mem_write_mem_nx     = 1'b0;
                    mem_write_address_nx = '0;
                    d_rvalid_nx          = 1'b1;
                    d_rdata_nx           = '0;
                    state_nx             = S_IDLE;
                end else begin
                    lat_cnt_nx = LAT_LOAD;
                    state_nx   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    if (owner_data) begin
                        d_rvalid_nx = 1'b1;
                        d_rdata_nx  = mem_read_data;
                    end else begin
                        if_rvalid_nx = 1'b1;
                        if_rdata_nx  = mem_read_data;
                    end
                    state_nx = S_IDLE;
                end else begin
                    lat_cnt_nx = lat_cnt - 2'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_stall <= '0;
            perf_d_stall  <= '0;
            perf_forced   <= '0;
        end else begin
            if (if_valid && !if_ready) perf_if_stall <= perf_if_stall + 32'd1;
            if (d_valid && !d_ready)   perf_d_stall  <= perf_d_stall + 32'd1;
            // A fetch grant with data also valid can only come from starvation.
            if (grant_if && d_valid)   perf_forced   <= perf_forced + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter at read latencies 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;

    // Instance with READ_LATENCY = 1
    logic        if_valid, if_ready, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_valid, d_ready, d_write, d_rvalid;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_write_mem, busy;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address, mem_write_data, mem_read_address, mem_read_data;

    // Instance with READ_LATENCY = 3
    logic        if_valid_3, if_ready_3, if_rvalid_3;
    logic [31:0] if_addr_3, if_rdata_3;
    logic        d_valid_3, d_ready_3, d_write_3, d_rvalid_3;
    logic [2:0]  d_funct3_3;
    logic [31:0] d_addr_3, d_wdata_3, d_rdata_3;
    logic        mem_write_mem_3, busy_3;
    logic [2:0]  mem_funct3_3;
    logic [31:0] mem_write_address_3, mem_write_data_3, mem_read_address_3, mem_read_data_3;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall, perf_d_stall, perf_forced;
    logic [31:0] perf_if_stall_3, perf_d_stall_3, perf_forced_3;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_write(d_write), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_write_mem(mem_write_mem), .mem_funct3(mem_funct3),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
        .busy(busy)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall), .perf_forced(perf_forced)
`endif
    );

    mem_port_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .rst(rst),
        .if_valid(if_valid_3), .if_ready(if_ready_3), .if_addr(if_addr_3),
        .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
        .d_valid(d_valid_3), .d_ready(d_ready_3), .d_write(d_write_3), .d_funct3(d_funct3_3),
        .d_addr(d_addr_3), .d_wdata(d_wdata_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
        .mem_write_mem(mem_write_mem_3), .mem_funct3(mem_funct3_3),
        .mem_write_address(mem_write_address_3), .mem_write_data(mem_write_data_3),
        .mem_read_address(mem_read_address_3), .mem_read_data(mem_read_data_3),
        .busy(busy_3)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_stall(perf_if_stall_3), .perf_d_stall(perf_d_stall_3), .perf_forced(perf_forced_3)
`endif
    );

    // Word memory with one registered read stage; word 4 (0x10) preloaded.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (rst) mem[4] <= 32'h0050_0093;
        else if (mem_write_mem) mem[mem_write_address[9:2]] <= mem_write_data;
        mem_read_data <= mem[mem_read_address[9:2]];
    end

    // Three-stage read pipe returning a known function of the address.
    logic [31:0] p1, p2;
    always @(posedge clk) begin
        p1              <= mem_read_address_3 ^ 32'h5A5A_0000;
        p2              <= p1;
        mem_read_data_3 <= p2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_valid = 0; if_addr = 0; d_valid = 0; d_write = 0; d_funct3 = 3'b010; d_addr = 0; d_wdata = 0;
        if_valid_3 = 0; if_addr_3 = 0; d_valid_3 = 0; d_write_3 = 0; d_funct3_3 = 3'b010;
        d_addr_3 = 0; d_wdata_3 = 0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_funct3", mem_funct3, 32'h2);
        check("rst_raddr", mem_read_address, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        rst = 1'b0;
        tick();

        // Single fetch, latency 1
        if_valid = 1; if_addr = 32'h10;
        #1 check("fetch_ready", if_ready, 1);
        check("fetch_d_ready", d_ready, 0);
        tick();
        if_valid = 0;
        check("fetch_busy", busy, 1);
        check("fetch_raddr", mem_read_address, 32'h10);
        check("fetch_funct3", mem_funct3, 32'h2);
        check("fetch_rv_e0", if_rvalid, 0);
        tick(); check("fetch_rv_e1", if_rvalid, 0);
        tick(); check("fetch_rv_e2", if_rvalid, 1);
        check("fetch_rdata", if_rdata, 32'h0050_0093);
        tick(); check("fetch_rv_e3", if_rvalid, 0);
        check("fetch_idle", busy, 0);

        // Store then load
        d_valid = 1; d_write = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
        #1 check("st_ready", d_ready, 1);
        tick();
        d_valid = 0;
        check("st_we", mem_write_mem, 1);
        check("st_waddr", mem_write_address, 32'h100);
        check("st_wdata", mem_write_data, 32'hDEAD_BEEF);
        check("st_ack_e0", d_rvalid, 0);
        tick();
        check("st_we_e1", mem_write_mem, 0);
        check("st_ack_e1", d_rvalid, 1);
        check("st_ack_data", d_rdata, 0);
        tick();
        check("st_ack_e2", d_rvalid, 0);
        d_valid = 1; d_write = 0;
        #1 check("ld_ready", d_ready, 1);
        tick();
        d_valid = 0;
        tick(); check("ld_rv_e1", d_rvalid, 0);
        tick(); check("ld_rv_e2", d_rvalid, 1);
        check("ld_rdata", d_rdata, 32'hDEAD_BEEF);
        tick(); check("ld_rv_e3", d_rvalid, 0);

        // Reset while a read waits on the memory
        if_valid = 1; if_addr = 32'h10;
        tick();
        if_valid = 0;
        tick();
        check("rw_busy_wait", busy, 1);
        rst = 1'b1;
        #1;
        check("rw_busy", busy, 0);
        check("rw_rvalid", if_rvalid, 0);
        check("rw_we", mem_write_mem, 0);
        check("rw_raddr", mem_read_address, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); check("rw_no_rvalid", if_rvalid, 0);
        end
        if_valid = 1;
        tick();
        if_valid = 0;
        tick();
        tick(); check("rw_again_rv", if_rvalid, 1);
        check("rw_again_data", if_rdata, 32'h0050_0093);
        tick();

        // Reset during a store drops the write enable at once
        d_valid = 1; d_write = 1; d_addr = 32'h104; d_wdata = 32'h1234_5678;
        tick();
        d_valid = 0;
        check("rs_we", mem_write_mem, 1);
        rst = 1'b1;
        #1;
        check("rs_we_drop", mem_write_mem, 0);
        check("rs_waddr", mem_write_address, 0);
        tick();
        rst = 1'b0;
        tick(); check("rs_no_ack0", d_rvalid, 0);
        tick(); check("rs_no_ack1", d_rvalid, 0);

        // Starvation: both valid continuously -> D D D D F repeating
        if_valid = 1; if_addr = 32'h10;
        d_valid = 1; d_write = 0; d_addr = 32'h100;
        for (int k = 0; k < 10; k++) begin
            int w;
            w = 0;
            @(negedge clk);
            while (!(if_ready || d_ready) && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("sv_grant_seen", (w < 20), 1);
            check("sv_one_ready", (if_ready && d_ready), 0);
            check("sv_fetch_wins", if_ready, ((k == 4) || (k == 9)));
            tick();
        end
        if_valid = 0; d_valid = 0;
        repeat (5) tick();
        check("sv_idle", busy, 0);
`ifdef MEM_ARB_PERF_EN
        check("perf_forced", perf_forced, 2);
`endif

        // Latency 3 load
        d_valid_3 = 1; d_write_3 = 0; d_addr_3 = 32'h40; d_funct3_3 = 3'b100;
        #1 check("l3_ready", d_ready_3, 1);
        tick();
        d_valid_3 = 0;
        check("l3_raddr", mem_read_address_3, 32'h40);
        check("l3_funct3", mem_funct3_3, 32'h4);
        for (int i = 1; i <= 3; i++) begin
            tick(); check("l3_rv_early", d_rvalid_3, 0);
        end
        tick(); check("l3_rv_e4", d_rvalid_3, 1);
        check("l3_rdata", d_rdata_3, 32'h5A5A_0040);
        tick(); check("l3_rv_e5", d_rvalid_3, 0);
        check("l3_raddr_hold", mem_read_address_3, 32'h40);

`ifdef MEM_ARB_PERF_EN
        // Load stalled behind a latency-3 fetch
        if_valid_3 = 1; if_addr_3 = 32'h20;
        tick();
        if_valid_3 = 0;
        d_valid_3 = 1; d_addr_3 = 32'h44; d_funct3_3 = 3'b010;
        tick(); tick();
        check("perf_d_e2", perf_d_stall_3, 2);
        tick(); tick();
        #1 check("perf_d_ready", d_ready_3, 1);
        tick();
        d_valid_3 = 0;
        check("perf_d_final", perf_d_stall_3, 4);
        check("perf_if_none", perf_if_stall_3, 0);
        repeat (6) tick();
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
